// File: rtl/transpose_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : transpose_sequencer
// Purpose  : Flow-controlled ROWS x COLS bit-matrix transpose: fill ROWS rows,
//            then stream COLS transposed columns. Optional: TRANSPOSE_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module transpose_sequencer #(
  parameter int ROWS = 32,
  parameter int COLS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [COLS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ROWS-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic            done
`ifdef TRANSPOSE_PARITY_EN
  ,
  input  logic            in_parity,
  output logic            out_parity,
  output logic            in_parity_err
`endif
);

  localparam int WW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [WW-1:0] C_WR_LAST = WW'(ROWS - 1);
  localparam logic [RW-1:0] C_RD_LAST = RW'(COLS - 1);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [RW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [COLS-1:0] mem_q [ROWS];
  logic [ROWS-1:0] w_col;
  logic            w_in_fire;
  logic            w_out_fire;

  // in_ready is gated by the reset input so it is low for the whole reset window
  assign in_ready   = reset && (state_q == S_FILL);
  assign out_valid  = (state_q == S_DRAIN);
  assign out_last   = out_valid && (rd_cnt_q == C_RD_LAST);
  assign out_data   = out_valid ? w_col : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign w_in_fire  = in_valid && in_ready && !abort;
  assign w_out_fire = out_valid && out_ready && !abort;

  for (genvar j = 0; j < ROWS; j++) begin : g_col
    assign w_col[j] = mem_q[j][rd_cnt_q];
  end

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d  = S_FILL;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (w_in_fire) begin
            busy_d = 1'b1;
            if (wr_cnt_q == C_WR_LAST) begin
              wr_cnt_d = '0;
              state_d  = S_DRAIN;
            end else begin
              wr_cnt_d = wr_cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            if (rd_cnt_q == C_RD_LAST) begin
              rd_cnt_d = '0;
              state_d  = S_FILL;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else begin
              rd_cnt_d = rd_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Storage is deliberately not reset; a matrix is only read after a full fill
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      mem_q[wr_cnt_q] <= in_data;
    end
  end

`ifdef TRANSPOSE_PARITY_EN
  logic parity_err_q;

  assign out_parity    = ^out_data;
  assign in_parity_err = parity_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= w_in_fire && ((^in_data) != in_parity);
    end
  end
`endif

endmodule
`default_nettype wire
